inst_fetch_queue: RTL

Parametrised successor to the single-register fetch stage. It decouples instruction SRAM reads from decode with a DEPTH-entry {pc, inst, adel} queue. Sequential fetches run ahead under credit control, so decode stalls no longer freeze the SRAM port, and a one-cycle redirect flushes the queue and any in-flight read. It sits between the PC/branch logic and the decode stage in the CPU top.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/inst_fetch_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector, fetch entry record and
// fetch mode encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } fetch_mode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Packed entry width for non-default PC/instruction widths.
  function automatic int entry_width(input int pc_w, input int inst_w);
    return pc_w + inst_w + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 65,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Storage carries no reset; readers qualify the head with count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Credit-controlled instruction fetch queue between PC/branch logic and decode.
// Misaligned fetches produce one address-error entry and halt until redirect.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     inst_sram_en,
  output logic [PC_W-1:0]          inst_sram_addr,
  input  logic [INST_W-1:0]        inst_sram_rdata,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [PC_W-1:0]          deq_pc,
  output logic [INST_W-1:0]        deq_inst,
  output logic                     deq_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(PC_W, INST_W);

  logic [PC_W-1:0]   fetch_pc_q;
  logic [PC_W-1:0]   fetch_pc_d;
  logic              inflight_q;
  logic              inflight_adel_q;
  logic [PC_W-1:0]   inflight_pc_q;
  fetch_mode_e       mode_q;

  logic [CW:0]       used;
  logic              credit_ok;
  logic              misaligned;
  logic              issue;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] resp_inst;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic [CW-1:0]     fifo_count;

  // Credit counts queued entries plus the read still in flight.
  assign used       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok  = used < (CW + 1)'(DEPTH);
  assign misaligned = |fetch_pc_q[1:0];
  assign issue      = (mode_q == MODE_RUN) && !redirect_valid && credit_ok;
  assign fetch_pc_d = fetch_pc_q + PC_W'(4);

  assign inst_sram_en   = resetn && issue && !misaligned;
  assign inst_sram_addr = fetch_pc_q;

  assign push      = inflight_q && !redirect_valid;
  assign resp_inst = inflight_adel_q ? {INST_W{1'b0}} : inst_sram_rdata;
  assign push_data = {inflight_pc_q, resp_inst, inflight_adel_q};

  assign deq_valid = (fifo_count != '0) && !redirect_valid;
  assign pop       = deq_valid && deq_ready;
  assign deq_pc    = deq_valid ? head[EW-1 -: PC_W] : '0;
  assign deq_inst  = deq_valid ? head[INST_W:1] : '0;
  assign deq_adel  = deq_valid && head[0];
  assign count     = fifo_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_adel_q <= 1'b0;
      inflight_pc_q   <= '0;
      mode_q          <= MODE_RUN;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
      mode_q     <= MODE_RUN;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q   <= fetch_pc_q;
        inflight_adel_q <= misaligned;
        if (misaligned) mode_q     <= MODE_HALT;
        else            fetch_pc_q <= fetch_pc_d;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (resetn),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

endmodule
